// File: rtl/hold_signal_pkg.sv
// Shared types and default parameters for the frame-based release extender.
package hold_signal_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDING = 2'd2
    } hold_state_t;

    localparam int DEFAULT_FRAMES_HOLD_WIDTH  = 5;
    localparam int DEFAULT_HOLD_FRAMES_AMOUNT = 5;

endpackage

// File: rtl/hold_signal_by_frames_if.sv
// Bundle of frame strobe, level input and extended outputs between game logic and the extender.
interface hold_signal_by_frames_if
    import hold_signal_pkg::*;
#(
    parameter int FRAMES_HOLD_WIDTH = DEFAULT_FRAMES_HOLD_WIDTH
);
    logic                         startOfFrame;
    logic                         input_signal;
    logic                         output_signal;
    logic                         hold_active;
    logic                         release_pulse;
    logic [FRAMES_HOLD_WIDTH-1:0] frames_left;

    modport master (
        output startOfFrame,
        output input_signal,
        input  output_signal,
        input  hold_active,
        input  release_pulse,
        input  frames_left
    );

    modport slave (
        input  startOfFrame,
        input  input_signal,
        output output_signal,
        output hold_active,
        output release_pulse,
        output frames_left
    );
endinterface

// File: rtl/hold_signal_by_frames.sv
// Extends a level signal for a programmable number of frame strobes after it falls.
// All outputs are registered from the next-state values, so they follow the state with no extra lag.
module hold_signal_by_frames
    import hold_signal_pkg::*;
#(
    parameter int FRAMES_HOLD_WIDTH  = DEFAULT_FRAMES_HOLD_WIDTH,
    parameter int HOLD_FRAMES_AMOUNT = DEFAULT_HOLD_FRAMES_AMOUNT
) (
    input  logic                    clk,
    input  logic                    reset,
    hold_signal_by_frames_if.slave  bus
);

    localparam logic [FRAMES_HOLD_WIDTH-1:0] HOLD_LOAD = FRAMES_HOLD_WIDTH'(HOLD_FRAMES_AMOUNT);
    localparam logic [FRAMES_HOLD_WIDTH-1:0] CNT_ONE   = FRAMES_HOLD_WIDTH'(1);
    localparam logic [FRAMES_HOLD_WIDTH-1:0] CNT_ZERO  = '0;

    hold_state_t                  r_state;
    logic [FRAMES_HOLD_WIDTH-1:0] r_cnt;
    logic                         r_output;
    logic                         r_hold;
    logic                         r_release;

    hold_state_t                  w_state_next;
    logic [FRAMES_HOLD_WIDTH-1:0] w_cnt_next;
    logic                         w_release_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= CNT_ZERO;
            r_output  <= 1'b0;
            r_hold    <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_output  <= (w_state_next != IDLE);
            r_hold    <= (w_state_next == HOLDING);
            r_release <= w_release_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_release_next = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_next = CNT_ZERO;
                if (bus.input_signal) begin
                    w_state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                // A strobe on the falling edge is deliberately not counted: the load wins.
                if (!bus.input_signal) begin
                    if (HOLD_FRAMES_AMOUNT != 0) begin
                        w_state_next = HOLDING;
                        w_cnt_next   = HOLD_LOAD;
                    end else begin
                        w_state_next   = IDLE;
                        w_cnt_next     = CNT_ZERO;
                        w_release_next = 1'b1;
                    end
                end
            end
            HOLDING: begin
                if (bus.input_signal) begin
                    w_state_next = ACTIVE;
                    w_cnt_next   = CNT_ZERO;
                end else if (bus.startOfFrame) begin
                    // Counter is never 0 here; treating <=1 as last frame keeps it from wrapping.
                    if (r_cnt <= CNT_ONE) begin
                        w_state_next   = IDLE;
                        w_cnt_next     = CNT_ZERO;
                        w_release_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt - CNT_ONE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = CNT_ZERO;
            end
        endcase
    end

    assign bus.output_signal = r_output;
    assign bus.hold_active   = r_hold;
    assign bus.release_pulse = r_release;
    assign bus.frames_left   = (r_state == HOLDING) ? r_cnt : CNT_ZERO;

endmodule
